// File: rtl/spi_transaction_fsm.sv
// spi_transaction_fsm
// Control FSM for the SPI memory slave. Over one chip-select transaction it sequences
// the 8-bit shift register, the address latch and the data memory. The transaction is
// a 7-bit address plus R/W bit, then one data byte that is either shifted in (write)
// or shifted out on MISO (read).
//
// Ports:
//   clk            system clock, rising-edge active
//   reset          asynchronous, active-high reset
//   sClkPosEdge    one-clk pulse on a conditioned SCLK rising edge
//   sClkNegEdge    one-clk pulse on a conditioned SCLK falling edge
//   csConditioned  conditioned chip select, active low
//   rwBit          shift register bit 0 after the address byte (1 = read, 0 = write)
//   srWE           shift register parallel-load enable (load from memory)
//   addrWE         address latch write enable
//   dmWE           data memory write enable
//   misoBufE       MISO tristate buffer enable
//   bitCount       registered bit counter (debug/verification)
//   busy           high in every state except idle
module spi_transaction_fsm #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned COUNT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sClkPosEdge,
    input  logic               sClkNegEdge,
    input  logic               csConditioned,
    input  logic               rwBit,
    output logic               srWE,
    output logic               addrWE,
    output logic               dmWE,
    output logic               misoBufE,
    output logic [COUNT_W-1:0] bitCount,
    output logic               busy
);

    typedef enum logic [3:0] {
        StIdle,
        StGetAddr,
        StGotAddr,
        StReadWait,
        StReadLoad,
        StReadSend,
        StWriteRecv,
        StWriteCommit,
        StDone
    } state_e;

    localparam logic [COUNT_W-1:0] CountTerm = COUNT_W'(WIDTH);

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] count_inc;

    assign count_inc = count_q + COUNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        // Chip-select release aborts from any active state, ahead of counting.
        if (state_q != StIdle && csConditioned) begin
            state_d = StIdle;
            count_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!csConditioned) begin
                        state_d = StGetAddr;
                        count_d = '0;
                    end
                end
                StGetAddr: begin
                    if (sClkPosEdge) begin
                        count_d = count_inc;
                        if (count_inc == CountTerm) state_d = StGotAddr;
                    end
                end
                StGotAddr: begin
                    count_d = '0;
                    state_d = rwBit ? StReadWait : StWriteRecv;
                end
                // One spare cycle so the memory read reflects the freshly latched address.
                StReadWait: state_d = StReadLoad;
                StReadLoad: state_d = StReadSend;
                StReadSend: begin
                    if (sClkNegEdge) begin
                        count_d = count_inc;
                        if (count_inc == CountTerm) state_d = StDone;
                    end
                end
                StWriteRecv: begin
                    if (sClkPosEdge) begin
                        count_d = count_inc;
                        if (count_inc == CountTerm) state_d = StWriteCommit;
                    end
                end
                StWriteCommit: state_d = StDone;
                // Counter stays frozen here until chip select releases.
                StDone: state_d = StDone;
                default: begin
                    state_d = StIdle;
                    count_d = '0;
                end
            endcase
        end
    end

    // Moore decode of the registered state.
    always_comb begin
        addrWE   = (state_q == StGotAddr);
        srWE     = (state_q == StReadLoad);
        dmWE     = (state_q == StWriteCommit);
        misoBufE = (state_q == StReadSend);
        busy     = (state_q != StIdle);
    end

    assign bitCount = count_q;

endmodule

// File: tb/tb_spi_transaction_fsm.sv
module tb_spi_transaction_fsm;

    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic          sClkPosEdge;
    logic          sClkNegEdge;
    logic          csConditioned;
    logic          rwBit;
    logic          srWE;
    logic          addrWE;
    logic          dmWE;
    logic          misoBufE;
    logic [CW-1:0] bitCount;
    logic          busy;

    spi_transaction_fsm #(
        .WIDTH  (8),
        .COUNT_W(CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sClkPosEdge  (sClkPosEdge),
        .sClkNegEdge  (sClkNegEdge),
        .csConditioned(csConditioned),
        .rwBit        (rwBit),
        .srWE         (srWE),
        .addrWE       (addrWE),
        .dmWE         (dmWE),
        .misoBufE     (misoBufE),
        .bitCount     (bitCount),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = inputs held for one clk, then the outputs expected after that clk edge.
    typedef struct packed {
        logic          cs;
        logic          pos;
        logic          neg;
        logic          rw;
        logic          addr;
        logic          sr;
        logic          dm;
        logic          miso;
        logic          bsy;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   row_id = 0;

    task automatic add(input logic cs, input logic pos, input logic neg, input logic rw,
                       input logic addr, input logic sr, input logic dm, input logic miso,
                       input logic bsy, input int cnt);
        vec_t v;
        v.cs   = cs;
        v.pos  = pos;
        v.neg  = neg;
        v.rw   = rw;
        v.addr = addr;
        v.sr   = sr;
        v.dm   = dm;
        v.miso = miso;
        v.bsy  = bsy;
        v.cnt  = CW'(cnt);
        vecs.push_back(v);
    endtask

    // Select, then eight address posedges ending in the address-latch cycle.
    task automatic add_addr(input logic rw);
        add(0, 0, 0, rw, 0, 0, 0, 0, 1, 0);
        for (int i = 1; i < 8; i++) add(0, 1, 0, rw, 0, 0, 0, 0, 1, i);
        add(0, 1, 0, rw, 1, 0, 0, 0, 1, 8);
    endtask

    // Write up to and including the commit cycle.
    task automatic add_write_commit();
        add_addr(1'b0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 1; i < 8; i++) add(0, 1, 0, 0, 0, 0, 0, 0, 1, i);
        add(0, 1, 0, 0, 0, 0, 1, 0, 1, 8);
    endtask

    task automatic add_write_done();
        add_write_commit();
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 8);
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        csConditioned = v.cs;
        sClkPosEdge   = v.pos;
        sClkNegEdge   = v.neg;
        rwBit         = v.rw;
        sb.push_back(v);
    endtask

    task automatic check_now(input string name, input logic [CW+4:0] got,
                             input logic [CW+4:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    // Scoreboard: pop one expected record per clk edge, shortly after the edge.
    initial begin
        vec_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                row_id++;
                check_now($sformatf("row%0d", row_id),
                          {addrWE, srWE, dmWE, misoBufE, busy, bitCount},
                          {e.addr, e.sr, e.dm, e.miso, e.bsy, e.cnt});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset         = 1'b1;
        csConditioned = 1'b1;
        sClkPosEdge   = 1'b0;
        sClkNegEdge   = 1'b0;
        rwBit         = 1'b0;

        // Write transaction, then release.
        add_write_done();
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Read transaction with posedges ignored in the send phase.
        add_addr(1'b1);
        add(0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++) add(0, 1, 0, 1, 0, 0, 0, 1, 1, 0);
        for (int i = 1; i < 8; i++) add(0, 0, 1, 1, 0, 0, 0, 1, 1, i);
        add(0, 0, 1, 1, 0, 0, 0, 0, 1, 8);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Negedges ignored while collecting the address; abort mid-address.
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
        add(0, 0, 1, 0, 0, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0, 0, 0, 0, 0, 1, 2);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // Abort after five data bits of a write: no commit.
        add_addr(1'b0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 5; i++) add(0, 1, 0, 0, 0, 0, 0, 0, 1, i);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Fresh write completes, then holds in done while more posedges arrive.
        add_write_done();
        for (int i = 0; i < 10; i++) add(0, 1, 0, 0, 0, 0, 0, 0, 1, 8);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Release during the commit cycle: the commit pulse already happened.
        add_write_commit();
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state while reset is held.
        #12;
        check_now("reset_hold", {addrWE, srWE, dmWE, misoBufE, busy, bitCount}, '0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        // Hand sequence: get three address bits in, then reset between clk edges.
        apply('{cs: 0, pos: 0, neg: 0, rw: 0, addr: 0, sr: 0, dm: 0, miso: 0, bsy: 1, cnt: 0});
        for (int i = 1; i <= 3; i++)
            apply('{cs: 0, pos: 1, neg: 0, rw: 0, addr: 0, sr: 0, dm: 0, miso: 0, bsy: 1,
                    cnt: CW'(i)});
        apply('{cs: 0, pos: 0, neg: 0, rw: 0, addr: 0, sr: 0, dm: 0, miso: 0, bsy: 1, cnt: 3});
        @(posedge clk);
        #3;
        check_now("pre_reset", {addrWE, srWE, dmWE, misoBufE, busy, bitCount},
                  {5'b00001, CW'(3)});
        reset = 1'b1;
        #1;
        check_now("async_reset", {addrWE, srWE, dmWE, misoBufE, busy, bitCount}, '0);
        csConditioned = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_now("post_reset_idle", {addrWE, srWE, dmWE, misoBufE, busy, bitCount}, '0);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
